// File: rtl/alu_pkg.sv
// Shared constants for the ALU BIST: opcodes, MISR/LFSR polynomials, FSM encoding, corner vectors.
package alu_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned OP_W       = 3;
   localparam int unsigned VEC_W      = 16;
   localparam int unsigned WAIT_W     = 4;
   localparam int unsigned NUM_CORNER = 3;

   localparam logic [OP_W-1:0] ALU_AND  = 3'd0;
   localparam logic [OP_W-1:0] ALU_OR   = 3'd1;
   localparam logic [OP_W-1:0] ALU_ADD  = 3'd2;
   localparam logic [OP_W-1:0] ALU_RSVD = 3'd3;
   localparam logic [OP_W-1:0] ALU_ANDN = 3'd4;
   localparam logic [OP_W-1:0] ALU_ORN  = 3'd5;
   localparam logic [OP_W-1:0] ALU_SUB  = 3'd6;
   localparam logic [OP_W-1:0] ALU_SLT  = 3'd7;

   localparam logic [DATA_W-1:0] MISR_POLY = 32'h04C11DB7;
   // Galois toggle mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
   localparam logic [DATA_W-1:0] LFSR_TAPS = 32'h80200003;

   localparam logic [DATA_W-1:0] VEC0_A = 32'h00000000;
   localparam logic [DATA_W-1:0] VEC0_B = 32'h00000000;
   localparam logic [DATA_W-1:0] VEC1_A = 32'hFFFFFFFF;
   localparam logic [DATA_W-1:0] VEC1_B = 32'h00000001;
   localparam logic [DATA_W-1:0] VEC2_A = 32'h80000000;
   localparam logic [DATA_W-1:0] VEC2_B = 32'h7FFFFFFF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_APPLY  = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_DONE   = 3'd4
   } bist_state_e;

   function automatic logic [DATA_W-1:0] misr_step(input logic [DATA_W-1:0] misr,
                                                   input logic [DATA_W-1:0] d);
      return ({misr[DATA_W-2:0], 1'b0} ^ (misr[DATA_W-1] ? MISR_POLY : '0)) ^ d;
   endfunction

endpackage

// File: rtl/alu_bist_if.sv
// BIST control/status plus the ALU operand/result bus; master = BIST engine, slave = ALU/host side.
interface alu_bist_if;
   logic        start;
   logic        busy;
   logic        done;
   logic        pass;
   logic [31:0] SrcAE;
   logic [31:0] SrcBE;
   logic [2:0]  ALUControlE;
   logic [31:0] ALUResultE;
   logic        ZeroE;
   logic [31:0] signature;
   logic [15:0] fail_count;

   modport master (
      input  start, ALUResultE, ZeroE,
      output busy, done, pass, SrcAE, SrcBE, ALUControlE, signature, fail_count
   );

   modport slave (
      output start, ALUResultE, ZeroE,
      input  busy, done, pass, SrcAE, SrcBE, ALUControlE, signature, fail_count
   );
endinterface

// File: rtl/alu_bist_lfsr.sv
// 32-bit Galois LFSR operand generator with synchronous reseed and single-step advance.
module alu_bist_lfsr
   import alu_pkg::*;
#(
   parameter logic [DATA_W-1:0] SEED = 32'hACE12024
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              i_load,
   input  logic              i_advance,
   output logic [DATA_W-1:0] o_state
);

   logic [DATA_W-1:0] r_state;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= SEED;
      end else if (i_load) begin
         r_state <= SEED;
      end else if (i_advance) begin
         r_state <= {1'b0, r_state[DATA_W-1:1]} ^ (r_state[0] ? LFSR_TAPS : '0);
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self-test: sweeps all opcodes over corner/LFSR operands into a 32-bit MISR.
// Define ALU_BIST_CHECK_EN to add a per-sample reference model feeding fail_count.
module alu_bist
   import alu_pkg::*;
#(
   parameter int unsigned       NUM_VECTORS = 64,
   parameter int unsigned       WAIT_CYCLES = 1,
   parameter logic [DATA_W-1:0] LFSR_SEED   = 32'hACE12024,
   parameter logic [DATA_W-1:0] GOLDEN_SIG  = 32'h00000000
) (
   input  logic       clock,
   input  logic       reset_n,
   alu_bist_if.master bus
);

   if (LFSR_SEED == '0) begin : g_seed_check
      $error("alu_bist: LFSR_SEED must be nonzero");
   end

   bist_state_e       r_state;
   logic [VEC_W-1:0]  r_vec;
   logic [OP_W-1:0]   r_op;
   logic [WAIT_W-1:0] r_wait;
   logic              r_busy, r_done, r_pass;
   logic [DATA_W-1:0] r_srca, r_srcb, r_misr;
   logic [15:0]       r_fail;

   logic [DATA_W-1:0] w_lfsr_a, w_lfsr_b, w_vec_a, w_vec_b, w_misr_next;
   logic [15:0]       w_fail_next;
   logic              w_start_acc, w_lfsr_adv, w_last_vec, w_pass_next;

   assign w_start_acc = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && bus.start;
   assign w_lfsr_adv  = (r_state == ST_LOAD) && (r_vec >= VEC_W'(NUM_CORNER));
   assign w_last_vec  = (r_vec == VEC_W'(NUM_VECTORS - 1));
   assign w_misr_next = misr_step(r_misr, bus.ALUResultE ^ {{(DATA_W-1){1'b0}}, ~bus.ZeroE});

   alu_bist_lfsr #(.SEED(LFSR_SEED)) u_lfsr_a (
      .clock(clock), .reset_n(reset_n), .i_load(w_start_acc),
      .i_advance(w_lfsr_adv), .o_state(w_lfsr_a)
   );

   alu_bist_lfsr #(.SEED(~LFSR_SEED)) u_lfsr_b (
      .clock(clock), .reset_n(reset_n), .i_load(w_start_acc),
      .i_advance(w_lfsr_adv), .o_state(w_lfsr_b)
   );

   always_comb begin
      w_vec_a = w_lfsr_a;
      w_vec_b = w_lfsr_b;
      case (r_vec)
         16'd0:   begin w_vec_a = VEC0_A; w_vec_b = VEC0_B; end
         16'd1:   begin w_vec_a = VEC1_A; w_vec_b = VEC1_B; end
         16'd2:   begin w_vec_a = VEC2_A; w_vec_b = VEC2_B; end
         default: ;
      endcase
   end

`ifdef ALU_BIST_CHECK_EN
   logic [DATA_W-1:0] w_ref;
   logic              w_ref_skip, w_mismatch;

   // Opcode 3 is unassigned in the ALU, so its response only feeds the signature.
   always_comb begin
      w_ref      = '0;
      w_ref_skip = 1'b0;
      case (r_op)
         ALU_AND:  w_ref = r_srca & r_srcb;
         ALU_OR:   w_ref = r_srca | r_srcb;
         ALU_ADD:  w_ref = r_srca + r_srcb;
         ALU_RSVD: w_ref_skip = 1'b1;
         ALU_ANDN: w_ref = r_srca & ~r_srcb;
         ALU_ORN:  w_ref = r_srca | ~r_srcb;
         ALU_SUB:  w_ref = r_srca - r_srcb;
         default:  w_ref = {{(DATA_W-1){1'b0}}, ($signed(r_srca) < $signed(r_srcb))};
      endcase
   end

   assign w_mismatch  = !w_ref_skip &&
                        ((bus.ALUResultE != w_ref) || (bus.ZeroE != (w_ref == '0)));
   assign w_fail_next = ((r_state == ST_SAMPLE) && w_mismatch && (r_fail != 16'hFFFF))
                        ? r_fail + 16'd1 : r_fail;
   assign w_pass_next = (w_misr_next == GOLDEN_SIG) && (w_fail_next == 16'd0);
`else
   assign w_fail_next = '0;
   assign w_pass_next = (w_misr_next == GOLDEN_SIG);
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_vec   <= '0;
         r_op    <= ALU_AND;
         r_wait  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_srca  <= '0;
         r_srcb  <= '0;
         r_misr  <= '0;
         r_fail  <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  r_state <= ST_LOAD;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_pass  <= 1'b0;
                  r_misr  <= '0;
                  r_fail  <= '0;
                  r_vec   <= '0;
                  r_op    <= ALU_AND;
               end
            end
            ST_LOAD: begin
               r_srca  <= w_vec_a;
               r_srcb  <= w_vec_b;
               r_op    <= ALU_AND;
               r_wait  <= '0;
               r_state <= ST_APPLY;
            end
            ST_APPLY: begin
               if (r_wait == WAIT_W'(WAIT_CYCLES - 1)) begin
                  r_state <= ST_SAMPLE;
               end else begin
                  r_wait <= r_wait + 4'd1;
               end
            end
            ST_SAMPLE: begin
               r_misr <= w_misr_next;
               r_fail <= w_fail_next;
               r_wait <= '0;
               if (r_op != ALU_SLT) begin
                  r_op    <= r_op + 3'd1;
                  r_state <= ST_APPLY;
               end else if (!w_last_vec) begin
                  r_vec   <= r_vec + 16'd1;
                  r_state <= ST_LOAD;
               end else begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= w_pass_next;
                  r_srca  <= '0;
                  r_srcb  <= '0;
                  r_op    <= ALU_AND;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.pass        = r_pass;
   assign bus.SrcAE       = r_srca;
   assign bus.SrcBE       = r_srcb;
   assign bus.ALUControlE = r_op;
   assign bus.signature   = r_misr;
   assign bus.fail_count  = r_fail;

endmodule

// File: tb/tb_alu_bist.sv
// Scoreboard bench for alu_bist: stub and behavioural ALUs, restart, ignored start, mid-run reset.
module tb_alu_bist;

   typedef enum int {M_ZERO, M_ONES, M_REAL, M_FAULT} mode_e;

   typedef struct {
      string       name;
      logic [31:0] sig;
      logic        pass;
      int          len;
      logic        chk_fc;
      logic [15:0] fc;
   } exp_t;

`ifdef ALU_BIST_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic  clock;
   logic  reset_n;
   mode_e mode;
   int    n_vec  = 0;
   int    n_miss = 0;
   exp_t  sb[$];

   alu_bist_if bus ();

   alu_bist #(
      .NUM_VECTORS(4),
      .WAIT_CYCLES(1),
      .LFSR_SEED  (32'hACE12024),
      .GOLDEN_SIG (32'h00000000)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a + b;
         3'd3:    return 32'h0;
         3'd4:    return a & ~b;
         3'd5:    return a | ~b;
         3'd6:    return a - b;
         default: return {31'b0, ($signed(a) < $signed(b))};
      endcase
   endfunction

   // ALU under test; M_FAULT sets result bit 5 on the vector-2 SLT sample only.
   logic [31:0] w_true;
   always_comb begin
      w_true         = alu_fn(bus.SrcAE, bus.SrcBE, bus.ALUControlE);
      bus.ALUResultE = 32'h0;
      bus.ZeroE      = 1'b1;
      case (mode)
         M_ZERO: begin bus.ALUResultE = 32'h0; bus.ZeroE = 1'b1; end
         M_ONES: begin bus.ALUResultE = 32'h0; bus.ZeroE = 1'b0; end
         M_REAL: begin bus.ALUResultE = w_true; bus.ZeroE = (w_true == 32'h0); end
         default: begin
            bus.ALUResultE = w_true;
            if (bus.SrcAE == 32'h80000000 && bus.SrcBE == 32'h7FFFFFFF && bus.ALUControlE == 3'd7)
               bus.ALUResultE = w_true | 32'h20;
            bus.ZeroE = (w_true == 32'h0);
         end
      endcase
   end

   // Expected signature for the four hand-listed operand pairs swept over all opcodes.
   function automatic logic [31:0] exp_sig(input bit fault);
      logic [31:0] va [4];
      logic [31:0] vb [4];
      logic [31:0] m, r, d;
      logic        z;
      va = '{32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'hACE12024};
      vb = '{32'h00000000, 32'h00000001, 32'h7FFFFFFF, 32'h531EDFDB};
      m  = 32'h0;
      for (int v = 0; v < 4; v++) begin
         for (int op = 0; op < 8; op++) begin
            r = alu_fn(va[v], vb[v], 3'(op));
            z = (r == 32'h0);
            if (fault && v == 2 && op == 7) r = r | 32'h20;
            d = r ^ {31'b0, ~z};
            m = {m[30:0], 1'b0} ^ (m[31] ? 32'h04C11DB7 : 32'h0) ^ d;
         end
      end
      return m;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: count busy cycles and score each completed run against the queue head.
   logic prev_busy = 1'b0;
   logic prev_done = 1'b0;
   int   busy_cnt  = 0;
   always @(negedge clock) begin
      exp_t e;
      if (bus.busy && !prev_busy) busy_cnt = 1;
      else if (bus.busy)          busy_cnt++;
      if (bus.done && !prev_done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check({e.name, "_sig"},  bus.signature, e.sig);
            check({e.name, "_pass"}, 32'(bus.pass), 32'(e.pass));
            check({e.name, "_len"},  32'(busy_cnt), 32'(e.len));
            if (e.chk_fc) check({e.name, "_fc"}, 32'(bus.fail_count), 32'(e.fc));
         end
      end
      prev_busy = bus.busy;
      prev_done = bus.done;
   end

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int i;
      for (i = 0; i < 2000 && !bus.done; i++) @(negedge clock);
      if (!bus.done) check({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_busy"}, 32'(bus.busy), 32'd0);
      check({name, "_done"}, 32'(bus.done), 32'd0);
      check({name, "_pass"}, 32'(bus.pass), 32'd0);
      check({name, "_srca"}, bus.SrcAE, 32'd0);
      check({name, "_srcb"}, bus.SrcBE, 32'd0);
      check({name, "_ctl"},  32'(bus.ALUControlE), 32'd0);
      check({name, "_sig"},  bus.signature, 32'd0);
      check({name, "_fc"},   32'(bus.fail_count), 32'd0);
   endtask

   task automatic run(input mode_e m, input exp_t e);
      mode = m;
      sb.push_back(e);
      pulse_start();
      wait_done(e.name);
      @(negedge clock);
   endtask

   initial begin
      logic [31:0] s_real, s_fault;
      exp_t e;
      s_real   = exp_sig(1'b0);
      s_fault  = exp_sig(1'b1);
      reset_n  = 1'b0;
      bus.start = 1'b0;
      mode     = M_ZERO;
      repeat (3) @(negedge clock);
      check_all_zero("reset");
      reset_n = 1'b1;
      @(negedge clock);

      // All-zero stub with ZeroE=1: every response compacts to zero.
      e = '{name: "zero_stub", sig: 32'h0, pass: !CHK, len: 68, chk_fc: 1'b0, fc: 16'h0};
      run(M_ZERO, e);

      // ZeroE=0 stub: d=1 per sample, 32 samples never reach bit 31 feedback.
      e = '{name: "ones_stub", sig: 32'hFFFFFFFF, pass: 1'b0, len: 68, chk_fc: 1'b0, fc: 16'h0};
      run(M_ONES, e);
      repeat (5) @(negedge clock);
      check("done_hold", 32'(bus.done), 32'd1);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_srca", bus.SrcAE, 32'd0);

      e = '{name: "real", sig: s_real, pass: (s_real == 32'h0), len: 68, chk_fc: 1'b1, fc: 16'h0};
      run(M_REAL, e);

      // Rerun with a start pulse at busy cycle 10: it must not lengthen the run.
      e.name = "real_rerun";
      mode = M_REAL;
      sb.push_back(e);
      pulse_start();
      repeat (9) @(negedge clock);
      pulse_start();
      wait_done(e.name);
      @(negedge clock);

      e = '{name: "fault", sig: s_fault, pass: (s_fault == 32'h0) && !CHK, len: 68,
            chk_fc: 1'b1, fc: CHK ? 16'd1 : 16'd0};
      run(M_FAULT, e);

      // Reset mid-run, then a fresh run must match an uninterrupted one.
      mode = M_REAL;
      pulse_start();
      repeat (29) @(negedge clock);
      reset_n = 1'b0;
      #1;
      check_all_zero("midrun_reset");
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      e = '{name: "after_reset", sig: s_real, pass: (s_real == 32'h0), len: 68,
            chk_fc: 1'b1, fc: 16'h0};
      run(M_REAL, e);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
